// File: rtl/btb_predictor_if.sv
// Fetch-side lookup and execute-side update bundle for the branch target buffer.
// The master drives the fetch PC and resolved outcomes; the slave returns the prediction.
interface btb_predictor_if;
    logic [31:0] pc;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        btb_predicted;
    logic [31:0] btb_predicted_address;

    modport master (
        output pc, flush, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
        input  btb_predicted, btb_predicted_address
    );

    modport slave (
        input  pc, flush, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
        output btb_predicted, btb_predicted_address
    );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from the fetch PC; one resolved outcome is written back per cycle.
module btb_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic           Clk,
    input  logic           Reset_n,
    btb_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    localparam logic [1:0] CTR_WEAK_NT  = 2'b01;
    localparam logic [1:0] CTR_WEAK_T   = 2'b10;
    localparam logic [1:0] CTR_STRONG_T = 2'b11;

    logic        r_valid  [ENTRIES];
    tag_t        r_tag    [ENTRIES];
    logic [31:0] r_target [ENTRIES];
    logic [1:0]  r_ctr    [ENTRIES];

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CTR_STRONG_T) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Lookup path: pure function of the fetch PC and current table contents.
    idx_t w_rd_idx;
    tag_t w_rd_tag;
    logic w_rd_hit;

    assign w_rd_idx = bus.pc[IDX_W+1:2];
    assign w_rd_tag = bus.pc[31:IDX_W+2];
    assign w_rd_hit = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);

    assign bus.btb_predicted         = w_rd_hit && r_ctr[w_rd_idx][1];
    assign bus.btb_predicted_address = bus.btb_predicted ? r_target[w_rd_idx] : 32'h0;

    // Update path: decide whether the indexed entry is rewritten and with what.
    idx_t        w_upd_idx;
    tag_t        w_upd_tag;
    logic        w_upd_hit;
    logic        w_upd_taken;
    logic        w_wr_en;
    logic [1:0]  w_wr_ctr;
    logic [31:0] w_wr_target;
    logic        w_unused_bits;

    assign w_upd_idx     = bus.upd_pc[IDX_W+1:2];
    assign w_upd_tag     = bus.upd_pc[31:IDX_W+2];
    assign w_upd_hit     = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_taken   = bus.upd_taken || bus.upd_is_jump;
    assign w_unused_bits = ^{bus.pc[1:0], bus.upd_pc[1:0]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_ctr    = r_ctr[w_upd_idx];
        w_wr_target = r_target[w_upd_idx];
        if (bus.upd_valid && !bus.flush) begin
            if (w_upd_hit) begin
                w_wr_en = 1'b1;
                if (bus.upd_is_jump) begin
                    w_wr_ctr    = CTR_STRONG_T;
                    w_wr_target = bus.upd_target;
                end else if (bus.upd_taken) begin
                    w_wr_ctr    = sat_inc(r_ctr[w_upd_idx]);
                    w_wr_target = bus.upd_target;
                end else begin
                    // Not-taken keeps the entry resident, even at counter zero.
                    w_wr_ctr = sat_dec(r_ctr[w_upd_idx]);
                end
            end else if (w_upd_taken) begin
                w_wr_en     = 1'b1;
                w_wr_ctr    = bus.upd_is_jump ? CTR_STRONG_T : CTR_WEAK_T;
                w_wr_target = bus.upd_target;
            end
        end
    end

    // NOTE: the table is a register array, not a RAM macro, so every field has a
    // defined reset value and the whole array is cleared asynchronously.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'h0;
                r_ctr[i]    <= CTR_WEAK_NT;
            end
        end else if (bus.flush) begin
            // Flush beats a simultaneous update; counters keep their history.
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_wr_en) begin
            // NOTE: non-blocking writes so a same-cycle lookup sees pre-update contents.
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= w_wr_target;
            r_ctr[w_upd_idx]    <= w_wr_ctr;
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios then random traffic,
// all compared against a table model built from plain arithmetic.
module tb_btb_predictor;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES);

    logic Clk;
    logic Reset_n;
    btb_predictor_if bus ();

    btb_predictor #(.ENTRIES(ENTRIES)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        bit          valid;
        int unsigned tag;
        logic [31:0] target;
        int          ctr;
    } ent_t;

    ent_t m [ENTRIES];

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return int'(a >> (IDX_W + 2));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m[i].valid  = 1'b0;
            m[i].tag    = 0;
            m[i].target = 32'h0;
            m[i].ctr    = 1;
        end
    endfunction

    function automatic void model_lookup(input logic [31:0] a, output bit pred, output logic [31:0] addr);
        int  i;
        bit  hit;
        i    = idx_of(a);
        hit  = m[i].valid && (m[i].tag == tag_of(a));
        pred = hit && (m[i].ctr >= 2);
        addr = pred ? m[i].target : 32'h0;
    endfunction

    // Applied at each rising edge using the inputs that were stable across it.
    function automatic void model_update();
        int i;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        if (bus.flush) begin
            for (int k = 0; k < ENTRIES; k++) m[k].valid = 1'b0;
            return;
        end
        if (!bus.upd_valid) return;
        i = idx_of(bus.upd_pc);
        if (m[i].valid && m[i].tag == tag_of(bus.upd_pc)) begin
            if (bus.upd_is_jump) begin
                m[i].ctr    = 3;
                m[i].target = bus.upd_target;
            end else if (bus.upd_taken) begin
                m[i].ctr    = (m[i].ctr + 1 > 3) ? 3 : m[i].ctr + 1;
                m[i].target = bus.upd_target;
            end else begin
                m[i].ctr = (m[i].ctr - 1 < 0) ? 0 : m[i].ctr - 1;
            end
        end else if (bus.upd_taken) begin
            m[i].valid  = 1'b1;
            m[i].tag    = tag_of(bus.upd_pc);
            m[i].target = bus.upd_target;
            m[i].ctr    = bus.upd_is_jump ? 3 : 2;
        end
    endfunction

    task automatic check(input string name);
        bit          ep;
        logic [31:0] ea;
        model_lookup(bus.pc, ep, ea);
        n_assert++;
        assert (bus.btb_predicted === ep) else begin
            n_fail++;
            $error("FAIL %s predicted pc=%h: got %b expected %b", name, bus.pc, bus.btb_predicted, ep);
        end
        n_assert++;
        assert (bus.btb_predicted_address === ea) else begin
            n_fail++;
            $error("FAIL %s address pc=%h: got %h expected %h", name, bus.pc, bus.btb_predicted_address, ea);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_update();
        @(negedge Clk);
    endtask

    task automatic idle_update();
        bus.flush       = 1'b0;
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = 32'h0;
        bus.upd_is_jump = 1'b0;
        bus.upd_taken   = 1'b0;
        bus.upd_target  = 32'h0;
    endtask

    // One cycle: drive lookup + update, check the lookup before the edge, then clock.
    task automatic cyc(input string name, input logic [31:0] lpc, input bit fl, input bit uv,
                       input logic [31:0] upc, input bit uj, input bit ut, input logic [31:0] utgt);
        bus.pc          = lpc;
        bus.flush       = fl;
        bus.upd_valid   = uv;
        bus.upd_pc      = upc;
        bus.upd_is_jump = uj;
        bus.upd_taken   = ut;
        bus.upd_target  = utgt;
        #1 check(name);
        tick();
        idle_update();
    endtask

    task automatic look(input string name, input logic [31:0] lpc);
        bus.pc = lpc;
        #1 check(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r_pc, r_upc, r_tgt;
        bit          r_j, r_t, r_uv, r_fl;

        idle_update();
        bus.pc  = 32'h0;
        Reset_n = 1'b0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);

        // Reset and cold lookup.
        n_assert++;
        assert (bus.btb_predicted === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_pred: got %b expected 0", bus.btb_predicted);
        end
        look("reset_cold", 32'h40);
        Reset_n = 1'b1;
        tick();
        look("cold_after_reset", 32'h40);

        // Branch allocate and train.
        cyc("alloc_same_cycle", 32'h40, 0, 1, 32'h40, 0, 1, 32'h100);
        look("alloc_hit", 32'h40);
        cyc("nt1", 32'h40, 0, 1, 32'h40, 0, 0, 32'h0);
        look("after_nt1", 32'h40);
        cyc("nt2", 32'h40, 0, 1, 32'h40, 0, 0, 32'h0);
        look("after_nt2", 32'h40);
        cyc("t1", 32'h40, 0, 1, 32'h40, 0, 1, 32'h100);
        look("after_t1", 32'h40);
        cyc("t2", 32'h40, 0, 1, 32'h40, 0, 1, 32'h100);
        look("after_t2", 32'h40);

        // Aliasing: 0x440 shares the index of 0x40 and evicts it.
        cyc("alias_upd", 32'h440, 0, 1, 32'h440, 0, 1, 32'h200);
        look("alias_old", 32'h40);
        look("alias_new", 32'h440);

        // Jump allocation and counter saturation.
        cyc("jump_alloc", 32'h80, 0, 1, 32'h80, 1, 1, 32'h300);
        for (int k = 0; k < 5; k++) cyc("sat_taken", 32'h80, 0, 1, 32'h80, 0, 1, 32'h300);
        look("sat_hit", 32'h80);
        cyc("sat_nt", 32'h80, 0, 1, 32'h80, 0, 0, 32'h0);
        look("after_sat_nt", 32'h80);

        // Flush wins over a simultaneous update.
        cyc("flush_upd", 32'h80, 1, 1, 32'hC0, 0, 1, 32'h400);
        look("flush_c0", 32'hC0);
        look("flush_40", 32'h40);
        look("flush_80", 32'h80);

        // Same-cycle lookup and update: no bypass.
        cyc("same_cycle", 32'h40, 0, 1, 32'h40, 0, 1, 32'h100);
        look("same_cycle_next", 32'h40);

        // Asynchronous reset between edges.
        #2 Reset_n = 1'b0;
        model_reset();
        #1 check("async_reset");
        Reset_n = 1'b1;
        tick();
        look("post_async_reset", 32'h40);

        // Random traffic over a few indices and tags to force hits, misses and aliasing.
        for (int n = 0; n < 600; n++) begin
            r_pc  = 32'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            r_upc = 32'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            r_tgt = $urandom & 32'hFFFF_FFFC;
            r_j   = ($urandom_range(0, 3) == 0);
            r_t   = r_j ? 1'b1 : 1'($urandom_range(0, 1));
            r_uv  = ($urandom_range(0, 3) != 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            cyc("rand", r_pc, r_fl, r_uv, r_upc, r_j, r_t, r_tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/btb_predictor.md
# btb_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, feeding the fetch-stage PC register. Each cycle it looks up the current fetch PC combinationally and drives `btb_predicted` / `btb_predicted_address` into the PC block. The execute stage writes resolved branch and jump outcomes back through a single update port, one per cycle.

## Interface
- `ENTRIES`, 16: number of entries. Power of two, 2..256. `IDX_W = log2(ENTRIES)`.
- `TAG_W`, `30 - IDX_W`: tag width, derived. Not user-set.
- `Clk` in 1: clock. All state updates happen on its rising edge.
- `Reset_n` in 1: one clock; reset is asynchronous and active-low. Clears all valid bits and sets every counter to 2'b01.
- `pc` in 32: current fetch PC; lookup key.
- `flush` in 1: synchronous invalidate of all entries. Counters are not touched.
- `upd_valid` in 1: an update is present this cycle.
- `upd_pc` in 32: PC of the resolved control-transfer instruction.
- `upd_is_jump` in 1: 1 = unconditional jump (JAL/JALR); 0 = conditional branch.
- `upd_taken` in 1: resolved direction. Must be 1 whenever `upd_is_jump` = 1.
- `upd_target` in 32: resolved target address.
- `btb_predicted` out 1: predict taken for `pc`.
- `btb_predicted_address` out 32: predicted target. Equals 0 whenever `btb_predicted` = 0.

## Operation
- Address split: `idx = pc[IDX_W+1:2]`, `tag = pc[31:IDX_W+2]`. `pc[1:0]` is ignored.
- Entry fields: `valid`, `tag[TAG_W]`, `target[32]`, `ctr[2]`.
- Lookup is purely combinational: `hit = valid[idx] && tag[idx] == pc tag`.
  - `btb_predicted = hit && ctr[idx][1]`.
  - `btb_predicted_address = btb_predicted ? target[idx] : 0`.
- Update when `upd_valid` = 1, using the index and tag taken from `upd_pc`:
  - **Hit, jump:** `ctr` := 2'b11; `target` := `upd_target`.
  - **Hit, branch taken:** `ctr` := `min(ctr+1, 3)`; `target` := `upd_target`.
  - **Hit, branch not taken:** `ctr` := `max(ctr-1, 0)`. Target and valid are unchanged; the entry stays valid at `ctr` = 0.
  - **Miss, taken (branch or jump):** allocate by overwriting the resident entry. Set `valid` = 1, new tag, `target` := `upd_target`, `ctr` := 2'b11 for a jump or 2'b10 for a branch.
  - **Miss, not taken:** no state change. No allocation.
- Counter arithmetic is 2-bit saturating. It never wraps 3→0 or 0→3.
- `flush` = 1 clears all `valid` bits at the edge. If `flush` and `upd_valid` are both asserted, `flush` wins and the update is dropped.
- Reset asserted mid-operation clears `valid` immediately. `btb_predicted` drops combinationally while `Reset_n` = 0.

## Timing
- Lookup latency is 0 cycles, combinational from `pc` and the table registers. The PC block registers the result at the same edge.
- An update written at edge N is visible to lookups from edge N onward; it affects outputs in cycle N+1.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents. There is no write-through bypass.
- Update throughput: one per cycle. No stall or back-pressure outputs.
- Reset values:
  - All `valid` = 0 and all `ctr` = 2'b01.
  - `tag` and `target` = 0.
  - `btb_predicted` = 0 and `btb_predicted_address` = 0.
- The block has no enable. The PC block's `Enable`/`PCWrite` decide whether the prediction is consumed.

## Test plan
- **Reset and cold lookup:** assert `Reset_n` = 0, release, drive `pc` = 0x0000_0040 → `btb_predicted` = 0, address = 0.
- **Branch allocate and train:** update `upd_pc` = 0x40, taken, target 0x100 → next cycle, `pc` = 0x40 gives predicted = 1, address 0x100.
  - Then two not-taken updates → predicted = 0 after the first (`ctr` 2→1) and after the second (`ctr` 0).
  - Then one taken → still 0 (`ctr` = 1).
  - Then a second taken → 1.
- **Aliasing:** with `ENTRIES` = 16, allocate 0x40 → 0x100, then taken update 0x440 → 0x200.
  - `pc` = 0x40 → predicted = 0.
  - `pc` = 0x440 → predicted = 1, address 0x200.
- **Jump and saturation:** jump update 0x80 → 0x300, then 5 taken updates → `ctr` stays 3. One not-taken → still predicted (`ctr` = 2).
- **Flush priority:** assert `flush` and `upd_valid` (0xC0 → 0x400, taken) in the same cycle → next cycle, `pc` = 0xC0 and `pc` = 0x40 both give predicted = 0.
- **Same-cycle read/update:** `pc` = 0x40 while updating 0x40 (miss, taken) → predicted = 0 that cycle, 1 the following cycle.
- **Async reset mid-run:** drop `Reset_n` between edges while predicted = 1 → output goes 0 without waiting for a clock edge.
